sha_schedule_ctrl: RTL and testbench
====================================

# sha_schedule_ctrl

Sequencer for the SHA-256 message-expansion datapath and the downstream compression rounds. Accepts one 512-bit block over a valid/ready handshake, drives the expansion unit's load strobe and word index through W[16..63], then streams round indices 0..63 to the compression core under backpressure. Sits between the miner's block/nonce generator and the expansion/compression pair; one block in flight at a time.

## Interface
- MSG_W, 512, message block width
- IDX_W, 7, expansion word-index width (matches expansion unit index port)

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- msg_valid  in  1  producer has a block on msg_in
- msg_ready  out  1  controller can accept a block (high only in IDLE)
- msg_in  in  MSG_W  block; captured on msg_valid && msg_ready
- abort  in  1  cancel current block, return to IDLE
- exp_msg  out  MSG_W  registered copy of accepted block, to expansion unit
- exp_load  out  1  load strobe to expansion unit (W[0..15] from exp_msg)
- exp_idx  out  IDX_W  word index to expansion unit
- rnd_valid  out  1  round index valid to compression core
- rnd_ready  in  1  compression core consumes current round
- rnd_idx  out  6  current round t (core reads W[t])
- rnd_last  out  1  rnd_valid && rnd_idx == 63
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after round 63 handshake

## Operation
- States: IDLE, LOAD, EXPAND, ROUND, DONE; all outputs Moore-decoded from state/counters.
- IDLE: msg_ready=1. On msg_valid: capture msg_in into exp_msg, -> LOAD.
- LOAD (1 cycle): exp_load=1 -> EXPAND with exp_idx=16.
- EXPAND: exp_idx increments each cycle 16..63; at 63 -> ROUND, rnd_idx=0.
- ROUND: rnd_valid=1; on rnd_ready, rnd_idx++; handshake at 63 -> DONE.
- DONE (1 cycle): done=1 -> IDLE.
- Parking: expansion unit rewrites W[exp_idx] every non-load cycle, so exp_idx = 63 in every state except EXPAND (recompute of W[63] is idempotent; inputs W[47],W[48],W[56],W[61] are stable). exp_idx never takes values 0..15 outside LOAD.
- abort: in LOAD/EXPAND/ROUND/DONE -> IDLE next cycle, no done pulse, exp_msg retained. Ignored in IDLE (a coincident msg_valid is accepted). Abort beats a same-cycle round-63 handshake.
- rnd_ready while rnd_valid=0 is ignored. rnd_idx holds while rnd_ready=0.
- exp_msg changes only on accept; stable for the block's lifetime.

## Timing
- Reset (async): state=IDLE, exp_idx=63, rnd_idx=0, exp_msg=0, exp_load=0, rnd_valid=0, rnd_last=0, busy=0, done=0, msg_ready=1.
- Accept in cycle N: LOAD N+1; EXPAND N+2..N+49 (48 cycles); ROUND from N+50.
- rnd_ready held high: round t handshake at N+50+t, done at N+114; next accept earliest N+115.
- Each stalled ROUND cycle delays done by exactly one cycle.
- Counters: exp_idx IDX_W bits, rnd_idx 6 bits; no wrap ever observed outside documented ranges.

## Structure
- Shared package sha_pkg: state enum, SHA_ROUNDS=64, SHA_EXP_FIRST=16, SHA_EXP_PARK=63.
- Single module; no sub-module needed. Counters and FSM in one always_ff, output decode in always_comb.

## Test plan
- Reset mid-ROUND (rst pulse at rnd_idx=20) -> all outputs at reset values same cycle, msg_ready=1.
- Accept block 0x00..01 at N, rnd_ready=1 -> exp_load only at N+1, exp_idx 16..63 over N+2..N+49, rnd_idx 0..63 over N+50..N+113, done at N+114, exp_msg equal to block throughout.
- rnd_ready low for rounds 10 and 40 (3 cycles each) -> rnd_idx holds, done at N+120, no index skipped.
- abort at exp_idx=30 -> IDLE next cycle, no rnd_valid, no done; exp_idx=63 from then on.
- abort coincident with round-63 handshake -> no done pulse, IDLE next cycle.
- msg_valid held high during busy -> not accepted until IDLE; exp_idx never in 0..15 in any cycle (assertion).

Source files
------------

// File: rtl/sha_pkg.sv
// Shared definitions for the SHA-256 schedule/round sequencer.
package sha_pkg;

    // Controller states; encoding is also exported on the debug port.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_EXPAND = 3'd2,
        ST_ROUND  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int SHA_ROUNDS    = 64;
    localparam int SHA_EXP_FIRST = 16;
    localparam int SHA_EXP_PARK  = 63;

endpackage

// File: rtl/sha_schedule_ctrl.sv
// Sequencer for SHA-256 message expansion and compression rounds.
// One block in flight: accept -> load W[0..15] -> expand W[16..63] ->
// stream round indices 0..63 to the compression core -> done pulse.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. msg_ready is high only in IDLE. rnd_valid is high in ROUND and
// does not depend on rnd_ready; rnd_idx holds until rnd_valid && rnd_ready.
module sha_schedule_ctrl
    import sha_pkg::*;
#(
    parameter int MSG_W = 512,
    parameter int IDX_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             msg_valid,
    output logic             msg_ready,
    input  logic [MSG_W-1:0] msg_in,
    input  logic             abort,
    output logic [MSG_W-1:0] exp_msg,
    output logic             exp_load,
    output logic [IDX_W-1:0] exp_idx,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic [5:0]       rnd_idx,
    output logic             rnd_last,
    output logic             busy,
    output logic             done,
    output logic [2:0]       dbg_state
);

    localparam logic [IDX_W-1:0] EXP_FIRST = IDX_W'(SHA_EXP_FIRST);
    localparam logic [IDX_W-1:0] EXP_PARK  = IDX_W'(SHA_EXP_PARK);
    localparam logic [5:0]       RND_LAST  = 6'(SHA_ROUNDS - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [IDX_W-1:0]   r_exp_idx;
    logic [5:0]         r_rnd_idx;
    logic [MSG_W-1:0]   r_exp_msg;
    logic               w_accept;
    logic               w_rnd_fire;

    assign w_accept   = (r_state == ST_IDLE) && msg_valid;
    assign w_rnd_fire = (r_state == ST_ROUND) && rnd_ready;

    // State register, block capture and the expansion/round counters.
    // exp_idx parks at 63 whenever the next state is not EXPAND, so the
    // expansion unit only ever recomputes W[63] outside the expansion pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_exp_idx <= EXP_PARK;
            r_rnd_idx <= 6'd0;
            r_exp_msg <= '0;
        end else begin
            r_state <= w_next_state;

            if (w_accept) begin
                r_exp_msg <= msg_in;
            end

            if (w_next_state == ST_EXPAND) begin
                r_exp_idx <= (r_state == ST_EXPAND) ? r_exp_idx + 1'b1 : EXP_FIRST;
            end else begin
                r_exp_idx <= EXP_PARK;
            end

            if (w_next_state != ST_ROUND) begin
                r_rnd_idx <= 6'd0;
            end else if (w_rnd_fire) begin
                r_rnd_idx <= r_rnd_idx + 6'd1;
            end
        end
    end

    // Next-state logic and Moore output decode.
    always_comb begin
        w_next_state = r_state;
        msg_ready    = 1'b0;
        exp_load     = 1'b0;
        rnd_valid    = 1'b0;
        rnd_last     = 1'b0;
        done         = 1'b0;
        busy         = (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                msg_ready = 1'b1;
                if (msg_valid) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                exp_load     = 1'b1;
                w_next_state = abort ? ST_IDLE : ST_EXPAND;
            end
            ST_EXPAND: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (r_exp_idx == EXP_PARK) begin
                    w_next_state = ST_ROUND;
                end
            end
            ST_ROUND: begin
                rnd_valid = 1'b1;
                rnd_last  = (r_rnd_idx == RND_LAST);
                // Abort wins over a same-cycle final handshake.
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (rnd_ready && (r_rnd_idx == RND_LAST)) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign exp_msg   = r_exp_msg;
    assign exp_idx   = r_exp_idx;
    assign rnd_idx   = r_rnd_idx;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_sha_schedule_ctrl.sv
// Directed bench for sha_schedule_ctrl with a round-index scoreboard.
module tb_sha_schedule_ctrl;

    localparam int MSG_W = 512;
    localparam int IDX_W = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             msg_valid;
    logic             msg_ready;
    logic [MSG_W-1:0] msg_in;
    logic             abort;
    logic [MSG_W-1:0] exp_msg;
    logic             exp_load;
    logic [IDX_W-1:0] exp_idx;
    logic             rnd_valid;
    logic             rnd_ready;
    logic [5:0]       rnd_idx;
    logic             rnd_last;
    logic             busy;
    logic             done;
    logic [2:0]       dbg_state;

    int vecs = 0;
    int errs = 0;
    logic [5:0] exp_q[$];

    sha_schedule_ctrl #(.MSG_W(MSG_W), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg_in    (msg_in),
        .abort     (abort),
        .exp_msg   (exp_msg),
        .exp_load  (exp_load),
        .exp_idx   (exp_idx),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .rnd_idx   (rnd_idx),
        .rnd_last  (rnd_last),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_msg(input string tag, input logic [MSG_W-1:0] obs, input logic [MSG_W-1:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals();
        chk32("rst_msg_ready", 32'(msg_ready), 1);
        chk32("rst_busy",      32'(busy), 0);
        chk32("rst_exp_idx",   32'(exp_idx), 63);
        chk32("rst_rnd_idx",   32'(rnd_idx), 0);
        chk32("rst_exp_load",  32'(exp_load), 0);
        chk32("rst_rnd_valid", 32'(rnd_valid), 0);
        chk32("rst_rnd_last",  32'(rnd_last), 0);
        chk32("rst_done",      32'(done), 0);
        chk_msg("rst_exp_msg", exp_msg, '0);
    endtask

    // Scoreboard: pop the expected round index on every round handshake;
    // also the expansion index must never sit in 0..15 outside a load.
    always @(negedge clk) begin
        logic [5:0] e;
        if (!rst && rnd_valid && rnd_ready) begin
            if (exp_q.size() == 0) begin
                vecs++;
                errs++;
                $error("FAIL rnd_unexpected: observed round %0d expected none", rnd_idx);
            end else begin
                e = exp_q.pop_front();
                chk32("rnd_idx_sb", 32'(rnd_idx), 32'(e));
                chk32("rnd_last_sb", 32'(rnd_last), 32'(e == 6'd63));
            end
        end
        if (!exp_load) begin
            chk32("exp_idx_range", 32'(exp_idx >= 7'd16), 1);
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!msg_ready && n < 300) begin
            step();
            n++;
        end
        chk32("ready_timeout", 32'(msg_ready), 1);
    endtask

    // Driver: accept one block at offset 0 and follow it cycle by cycle.
    // stall: rnd_ready low for 3 cycles at rounds 10 and 40.
    // hold: keep msg_valid high (with another block) while busy.
    // abort_off / rst_off: offset at which to abort / pulse reset (0 = never).
    // exp_done: offset of the expected done pulse (0 = none expected).
    task automatic run_block(input logic [MSG_W-1:0] msg, input bit stall, input bit hold,
                             input logic [MSG_W-1:0] other, input int abort_off,
                             input int rst_off, input int exp_done);
        wait_ready();
        msg_valid = 1'b1;
        msg_in    = msg;
        for (int t = 0; t < 64; t++) exp_q.push_back(6'(t));
        step();
        if (hold) msg_in = other;
        else msg_valid = 1'b0;

        for (int off = 1; off <= 200; off++) begin
            rnd_ready = !(stall && ((off >= 60 && off <= 62) || (off >= 93 && off <= 95)));
            chk32("exp_load", 32'(exp_load), 32'(off == 1));
            if (off >= 2 && off <= 49) chk32("exp_idx", 32'(exp_idx), 32'(off + 14));
            else chk32("exp_idx_park", 32'(exp_idx), 63);
            if (!stall) begin
                chk32("rnd_valid", 32'(rnd_valid), 32'(off >= 50 && off <= 113));
                if (off >= 50 && off <= 113) chk32("rnd_idx", 32'(rnd_idx), 32'(off - 50));
            end
            chk_msg("exp_msg_stable", exp_msg, msg);
            chk32("msg_ready_busy", 32'(msg_ready), 0);
            chk32("busy", 32'(busy), 1);
            chk32("done", 32'(done), 32'(off == exp_done));
            if (off == exp_done) begin
                chk32("q_empty", 32'(exp_q.size()), 0);
                return;
            end
            if (off == rst_off) begin
                rst = 1'b1;
                #1;
                check_reset_vals();
                rst = 1'b0;
                exp_q.delete();
                return;
            end
            if (off == abort_off) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                exp_q.delete();
                for (int k = 0; k < 5; k++) begin
                    chk32("abort_busy", 32'(busy), 0);
                    chk32("abort_ready", 32'(msg_ready), 1);
                    chk32("abort_done", 32'(done), 0);
                    chk32("abort_rnd_valid", 32'(rnd_valid), 0);
                    chk32("abort_exp_idx", 32'(exp_idx), 63);
                    chk_msg("abort_exp_msg", exp_msg, msg);
                    step();
                end
                return;
            end
            step();
        end
    endtask

    initial begin
        logic [MSG_W-1:0] m;
        logic [MSG_W-1:0] blk_a;
        logic [MSG_W-1:0] blk_b;

        rst = 1'b0;
        msg_valid = 1'b0;
        msg_in = '0;
        abort = 1'b0;
        rnd_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_reset_vals();
        step();
        step();
        rst = 1'b0;
        rnd_ready = 1'b1;

        // Nominal block, msg_valid held high with another block while busy.
        blk_a = '0;
        blk_a[0] = 1'b1;
        blk_b = {16{32'hA5A5_5A5A}};
        run_block(blk_a, 1'b0, 1'b1, blk_b, 0, 0, 114);
        step();
        chk32("idle_after_done", 32'(msg_ready), 1);
        chk32("idle_busy", 32'(busy), 0);
        chk_msg("exp_msg_before_next", exp_msg, blk_a);
        step();
        chk32("held_accept_load", 32'(exp_load), 1);
        chk_msg("held_accept_msg", exp_msg, blk_b);
        msg_valid = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk32("abort_load_busy", 32'(busy), 0);
        chk32("abort_load_done", 32'(done), 0);
        chk_msg("abort_load_msg", exp_msg, blk_b);

        // Stalls at rounds 10 and 40, three cycles each.
        for (int i = 0; i < 16; i++) m[i*32 +: 32] = $urandom();
        run_block(m, 1'b1, 1'b0, '0, 0, 0, 120);

        // Abort during expansion at exp_idx = 30.
        for (int i = 0; i < 16; i++) m[i*32 +: 32] = $urandom();
        run_block(m, 1'b0, 1'b0, '0, 16, 0, 0);

        // Abort coincident with the round-63 handshake.
        for (int i = 0; i < 16; i++) m[i*32 +: 32] = $urandom();
        run_block(m, 1'b0, 1'b0, '0, 113, 0, 0);

        // Reset pulse mid-ROUND at rnd_idx = 20.
        for (int i = 0; i < 16; i++) m[i*32 +: 32] = $urandom();
        run_block(m, 1'b0, 1'b0, '0, 0, 70, 0);

        // Recovery: a full block after the reset.
        for (int i = 0; i < 16; i++) m[i*32 +: 32] = $urandom();
        run_block(m, 1'b0, 1'b0, '0, 0, 0, 114);
        step();
        chk32("final_idle", 32'(msg_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
